// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM bus.
// Tracks outstanding reads in an ID FIFO so in-order RAM responses are
// routed back to the master that issued them.
module ram_bus_arbiter #(
    parameter int unsigned PENDING_DEPTH = 4
) (
    input  logic        io_mainClk,
    input  logic        resetCtrl_systemReset,

    input  logic        m0_cmd_valid,
    output logic        m0_cmd_ready,
    input  logic        m0_cmd_payload_write,
    input  logic [31:0] m0_cmd_payload_address,
    input  logic [31:0] m0_cmd_payload_data,
    input  logic [3:0]  m0_cmd_payload_mask,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_payload_data,

    input  logic        m1_cmd_valid,
    output logic        m1_cmd_ready,
    input  logic        m1_cmd_payload_write,
    input  logic [31:0] m1_cmd_payload_address,
    input  logic [31:0] m1_cmd_payload_data,
    input  logic [3:0]  m1_cmd_payload_mask,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_payload_data,

    output logic        s_cmd_valid,
    input  logic        s_cmd_ready,
    output logic        s_cmd_payload_write,
    output logic [31:0] s_cmd_payload_address,
    output logic [31:0] s_cmd_payload_data,
    output logic [3:0]  s_cmd_payload_mask,
    input  logic        s_rsp_valid,
    input  logic [31:0] s_rsp_payload_data,

    output logic        rsp_orphan
);

    localparam int unsigned CNT_W = $clog2(PENDING_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(PENDING_DEPTH);

    logic                     last_grant;
    logic                     lock_active;
    logic                     lock_id;
    logic [CNT_W-1:0]         pending;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PENDING_DEPTH-1:0] id_fifo;

    logic winner;
    logic win_valid;
    logic win_write;
    logic blocked;
    logic s_fire;
    logic push;
    logic pop;
    logic head_id;

    // Pick the winner: a stalled command keeps its grant, otherwise round-robin.
    always_comb begin
        winner = ~last_grant;
        if (lock_active) begin
            winner = lock_id;
        end else if (m0_cmd_valid && !m1_cmd_valid) begin
            winner = 1'b0;
        end else if (m1_cmd_valid && !m0_cmd_valid) begin
            winner = 1'b1;
        end
    end

    // Zero-cycle command path from the winner to the RAM, with read blocking.
    always_comb begin
        win_valid             = winner ? m1_cmd_valid : m0_cmd_valid;
        win_write             = winner ? m1_cmd_payload_write : m0_cmd_payload_write;
        s_cmd_payload_write   = win_write;
        s_cmd_payload_address = winner ? m1_cmd_payload_address : m0_cmd_payload_address;
        s_cmd_payload_data    = winner ? m1_cmd_payload_data : m0_cmd_payload_data;
        s_cmd_payload_mask    = winner ? m1_cmd_payload_mask : m0_cmd_payload_mask;
        blocked               = !win_write && (pending == CNT_W'(PENDING_DEPTH));
        s_cmd_valid           = win_valid && !blocked;
        m0_cmd_ready          = !winner && s_cmd_ready && !blocked;
        m1_cmd_ready          = winner && s_cmd_ready && !blocked;
        s_fire                = s_cmd_valid && s_cmd_ready;
        push                  = s_fire && !win_write;
    end

    // Route a RAM response to the master at the head of the ID FIFO.
    always_comb begin
        pop                 = s_rsp_valid && (pending != '0) && !resetCtrl_systemReset;
        head_id             = id_fifo[rd_ptr];
        m0_rsp_valid        = pop && !head_id;
        m1_rsp_valid        = pop && head_id;
        m0_rsp_payload_data = s_rsp_payload_data;
        m1_rsp_payload_data = s_rsp_payload_data;
    end

    // Grant history and stall lock.
    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            last_grant  <= 1'b1;
            lock_active <= 1'b0;
            lock_id     <= 1'b0;
        end else begin
            if (s_fire) begin
                last_grant <= winner;
            end
            lock_active <= s_cmd_valid && !s_cmd_ready;
            lock_id     <= winner;
        end
    end

    // Outstanding-read ID FIFO and occupancy count.
    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            pending <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            id_fifo <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                pending <= pending + CNT_W'(1);
            end else if (pop && !push) begin
                pending <= pending - CNT_W'(1);
            end
        end
    end

    // Sticky flag for a response that arrived with nothing outstanding.
    always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
        if (resetCtrl_systemReset) begin
            rsp_orphan <= 1'b0;
        end else if (s_rsp_valid && (pending == '0)) begin
            rsp_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_ram_bus_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_payload_write;
    logic [31:0] m0_cmd_payload_address, m0_cmd_payload_data;
    logic [3:0]  m0_cmd_payload_mask;
    logic        m0_rsp_valid;
    logic [31:0] m0_rsp_payload_data;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_payload_write;
    logic [31:0] m1_cmd_payload_address, m1_cmd_payload_data;
    logic [3:0]  m1_cmd_payload_mask;
    logic        m1_rsp_valid;
    logic [31:0] m1_rsp_payload_data;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_payload_write;
    logic [31:0] s_cmd_payload_address, s_cmd_payload_data;
    logic [3:0]  s_cmd_payload_mask;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_payload_data;
    logic        rsp_orphan;

    always #5 clk = ~clk;

    ram_bus_arbiter #(.PENDING_DEPTH(DEPTH)) dut (
        .io_mainClk            (clk),
        .resetCtrl_systemReset (rst),
        .m0_cmd_valid          (m0_cmd_valid),
        .m0_cmd_ready          (m0_cmd_ready),
        .m0_cmd_payload_write  (m0_cmd_payload_write),
        .m0_cmd_payload_address(m0_cmd_payload_address),
        .m0_cmd_payload_data   (m0_cmd_payload_data),
        .m0_cmd_payload_mask   (m0_cmd_payload_mask),
        .m0_rsp_valid          (m0_rsp_valid),
        .m0_rsp_payload_data   (m0_rsp_payload_data),
        .m1_cmd_valid          (m1_cmd_valid),
        .m1_cmd_ready          (m1_cmd_ready),
        .m1_cmd_payload_write  (m1_cmd_payload_write),
        .m1_cmd_payload_address(m1_cmd_payload_address),
        .m1_cmd_payload_data   (m1_cmd_payload_data),
        .m1_cmd_payload_mask   (m1_cmd_payload_mask),
        .m1_rsp_valid          (m1_rsp_valid),
        .m1_rsp_payload_data   (m1_rsp_payload_data),
        .s_cmd_valid           (s_cmd_valid),
        .s_cmd_ready           (s_cmd_ready),
        .s_cmd_payload_write   (s_cmd_payload_write),
        .s_cmd_payload_address (s_cmd_payload_address),
        .s_cmd_payload_data    (s_cmd_payload_data),
        .s_cmd_payload_mask    (s_cmd_payload_mask),
        .s_rsp_valid           (s_rsp_valid),
        .s_rsp_payload_data    (s_rsp_payload_data),
        .rsp_orphan            (rsp_orphan)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: who was granted last, stall lock, issue-order queue.
    int m_last;
    bit m_lock;
    int m_lock_id;
    int q[$];
    bit m_orphan;

    // Per-cycle decisions carried from the check phase to the clock edge.
    int e_win;
    bit e_fire, e_read, e_pop, e_orph, e_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_last    = 1;
        m_lock    = 1'b0;
        m_lock_id = 0;
        q.delete();
        m_orphan  = 1'b0;
    endtask

    // Compare every DUT output against the model mid-cycle.
    task automatic cyc_check();
        int win;
        bit wv, ww, blk, sv, e0, e1;
        @(negedge clk);
        if (m_lock) win = m_lock_id;
        else if (m0_cmd_valid && !m1_cmd_valid) win = 0;
        else if (m1_cmd_valid && !m0_cmd_valid) win = 1;
        else win = 1 - m_last;
        wv  = (win == 1) ? m1_cmd_valid : m0_cmd_valid;
        ww  = (win == 1) ? m1_cmd_payload_write : m0_cmd_payload_write;
        blk = !ww && (q.size() == DEPTH);
        sv  = wv && !blk;
        chk("s_cmd_valid", 32'(s_cmd_valid), 32'(sv));
        chk("m0_cmd_ready", 32'(m0_cmd_ready), 32'(win == 0 && s_cmd_ready && !blk));
        chk("m1_cmd_ready", 32'(m1_cmd_ready), 32'(win == 1 && s_cmd_ready && !blk));
        if (sv) begin
            chk("s_cmd_write", 32'(s_cmd_payload_write), 32'(ww));
            chk("s_cmd_address", s_cmd_payload_address,
                (win == 1) ? m1_cmd_payload_address : m0_cmd_payload_address);
            chk("s_cmd_data", s_cmd_payload_data,
                (win == 1) ? m1_cmd_payload_data : m0_cmd_payload_data);
            chk("s_cmd_mask", 32'(s_cmd_payload_mask),
                32'((win == 1) ? m1_cmd_payload_mask : m0_cmd_payload_mask));
        end
        e_pop = s_rsp_valid && (q.size() > 0) && !rst;
        e0 = e_pop && (q[0] == 0);
        e1 = e_pop && (q[0] == 1);
        chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(e0));
        chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(e1));
        chk("m0_rsp_data", m0_rsp_payload_data, s_rsp_payload_data);
        chk("m1_rsp_data", m1_rsp_payload_data, s_rsp_payload_data);
        chk("rsp_orphan", 32'(rsp_orphan), 32'(m_orphan));
        e_win  = win;
        e_fire = sv && s_cmd_ready;
        e_read = !ww;
        e_orph = s_rsp_valid && (q.size() == 0) && !rst;
        e_lock = sv && !s_cmd_ready;
    endtask

    // Advance the model at the clock edge, then step off the edge.
    task automatic cyc_end();
        @(posedge clk);
        if (!rst) begin
            if (e_pop) void'(q.pop_front());
            if (e_orph) m_orphan = 1'b1;
            if (e_fire) begin
                m_last = e_win;
                if (e_read) q.push_back(e_win);
            end
            m_lock    = e_lock;
            m_lock_id = e_win;
        end
        #1;
    endtask

    task automatic cmd(input int n, input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        if (n == 0) begin
            m0_cmd_valid = v; m0_cmd_payload_write = w; m0_cmd_payload_address = a;
            m0_cmd_payload_data = d; m0_cmd_payload_mask = m;
        end else begin
            m1_cmd_valid = v; m1_cmd_payload_write = w; m1_cmd_payload_address = a;
            m1_cmd_payload_data = d; m1_cmd_payload_mask = m;
        end
    endtask

    task automatic rsp(input bit v, input logic [31:0] d);
        s_rsp_valid = v;
        s_rsp_payload_data = d;
    endtask

    task automatic idle();
        cmd(0, 0, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 0, 0);
        rsp(0, 0);
    endtask

    task automatic plain_cycle();
        cyc_check();
        cyc_end();
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        idle();
        s_cmd_ready = 1'b1;

        // Reset: command path live, responses suppressed, orphan clear.
        cmd(0, 1, 0, 32'h0000_0004, 0, 4'hF);
        rsp(1, 32'hDEAD_BEEF);
        #2;
        cyc_check();
        chk("rst_m0_ready", 32'(m0_cmd_ready), 32'd1);
        chk("rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        chk("rst_orphan", 32'(rsp_orphan), 32'd0);
        cyc_end();
        plain_cycle();
        idle();
        rst = 1'b0;
        plain_cycle();

        // Tie from reset: m0, m1, m0, m1.
        cmd(0, 1, 0, 32'h0000_0100, 0, 4'hF);
        cmd(1, 1, 0, 32'h0000_0200, 0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            cyc_check();
            chk("tie_m0_ready", 32'(m0_cmd_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_m1_ready", 32'(m1_cmd_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            cyc_end();
        end
        idle();
        // Drain in issue order: m0, m1, m0, m1.
        for (int i = 0; i < 4; i++) begin
            rsp(1, 32'h1000_0000 + 32'(i));
            cyc_check();
            chk("order_m1_rsp", 32'(m1_rsp_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
            cyc_end();
        end
        idle();

        // One-cycle RAM: m0 read 0x10 then m1 read 0x20.
        cmd(0, 1, 0, 32'h0000_0010, 0, 4'hF);
        cyc_check();
        chk("ram1_addr0", s_cmd_payload_address, 32'h0000_0010);
        cyc_end();
        cmd(0, 0, 0, 0, 0, 0);
        cmd(1, 1, 0, 32'h0000_0020, 0, 4'hF);
        rsp(1, 32'hAAAA_0010);
        cyc_check();
        chk("ram1_m0_rsp", 32'(m0_rsp_valid), 32'd1);
        chk("ram1_m0_data", m0_rsp_payload_data, 32'hAAAA_0010);
        chk("ram1_addr1", s_cmd_payload_address, 32'h0000_0020);
        cyc_end();
        cmd(1, 0, 0, 0, 0, 0);
        rsp(1, 32'hBBBB_0020);
        cyc_check();
        chk("ram1_m1_rsp", 32'(m1_rsp_valid), 32'd1);
        chk("ram1_m1_data", m1_rsp_payload_data, 32'hBBBB_0020);
        cyc_end();
        idle();

        // Stall: m1 holds the bus while ready is low, even once m0 requests.
        s_cmd_ready = 1'b0;
        cmd(1, 1, 1, 32'h0000_0300, 32'h0000_1234, 4'hF);
        plain_cycle();
        cmd(0, 1, 0, 32'h0000_0040, 0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            cyc_check();
            chk("stall_addr", s_cmd_payload_address, 32'h0000_0300);
            chk("stall_m0_ready", 32'(m0_cmd_ready), 32'd0);
            cyc_end();
        end
        s_cmd_ready = 1'b1;
        cyc_check();
        chk("stall_m1_fire", 32'(m1_cmd_ready), 32'd1);
        cyc_end();
        cmd(1, 0, 0, 0, 0, 0);
        cyc_check();
        chk("stall_m0_fire", 32'(m0_cmd_ready), 32'd1);
        cyc_end();
        idle();
        rsp(1, 32'h0000_0040);
        plain_cycle();
        idle();

        // Full: four m0 reads, then a concurrent m1 write still fires.
        for (int i = 0; i < 4; i++) begin
            cmd(0, 1, 0, 32'h0000_0050 + 32'(4 * i), 0, 4'hF);
            plain_cycle();
        end
        cmd(0, 1, 0, 32'h0000_0060, 0, 4'hF);
        cmd(1, 1, 1, 32'h0000_0400, 32'h5555_AAAA, 4'b0101);
        cyc_check();
        chk("full_m0_ready", 32'(m0_cmd_ready), 32'd0);
        chk("full_m1_ready", 32'(m1_cmd_ready), 32'd1);
        chk("full_mask", 32'(s_cmd_payload_mask), 32'h5);
        cyc_end();
        cmd(1, 0, 0, 0, 0, 0);
        rsp(1, 32'h0000_0050);
        cyc_check();
        chk("full_blocked_valid", 32'(s_cmd_valid), 32'd0);
        chk("full_pop_m0", 32'(m0_rsp_valid), 32'd1);
        cyc_end();
        rsp(1, 32'h0000_0054);
        cyc_check();
        chk("full_unblock", 32'(m0_cmd_ready), 32'd1);
        cyc_end();
        cmd(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rsp(1, 32'h0000_0058 + 32'(4 * i));
            plain_cycle();
        end
        idle();

        // Orphan: response with nothing outstanding is dropped and flagged.
        rsp(1, 32'h0BAD_0BAD);
        cyc_check();
        chk("orph_m0_rsp", 32'(m0_rsp_valid), 32'd0);
        chk("orph_m1_rsp", 32'(m1_rsp_valid), 32'd0);
        cyc_end();
        idle();
        for (int i = 0; i < 2; i++) begin
            cyc_check();
            chk("orph_sticky", 32'(rsp_orphan), 32'd1);
            cyc_end();
        end
        rst = 1'b1;
        model_clear();
        #1;
        chk("orph_cleared", 32'(rsp_orphan), 32'd0);
        plain_cycle();
        rst = 1'b0;
        plain_cycle();

        // Reset mid-transaction discards outstanding read IDs.
        cmd(0, 1, 0, 32'h0000_0070, 0, 4'hF);
        plain_cycle();
        plain_cycle();
        idle();
        rst = 1'b1;
        model_clear();
        rsp(1, 32'h0000_0070);
        plain_cycle();
        rst = 1'b0;
        cyc_check();
        chk("rstmid_m0_rsp", 32'(m0_rsp_valid), 32'd0);
        cyc_end();
        idle();
        cyc_check();
        chk("rstmid_orphan", 32'(rsp_orphan), 32'd1);
        cyc_end();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
